serial_subtractor: RTL

- Parametrised bit-serial subtractor; the sequential successor to the single-bit half/full subtractor cells.
- Computes diff = a - b - borrow_in over WIDTH bits, LSB first, one bit per clock, using one full-subtractor cell and a borrow flip-flop.
- Uses a start/busy/done handshake.
- Sits beside the combinational arithmetic blocks as the area-minimal multi-bit subtract unit.

---
 rtl/serial_subtractor_if.sv | 52 +++++
 rtl/serial_subtractor.sv | 131 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//   Handshake/operand bundle for the bit-serial subtractor.
//
//   Signals:
//     start      requester -> unit   start request, sampled only while idle
//     a, b       requester -> unit   minuend / subtrahend (WIDTH bits)
//     borrow_in  requester -> unit   initial borrow
//     busy       unit -> requester   high while an operation is in flight
//     done       unit -> requester   one-cycle pulse, result valid
//     diff       unit -> requester   registered difference (WIDTH bits)
//     borrow_out unit -> requester   registered final borrow
//     ovf        unit -> requester   signed overflow (only with SERIAL_SUB_OVF_EN)
//
//   Modports: master (requester side), slave (subtractor side).
//   Optional macro: SERIAL_SUB_OVF_EN adds the ovf signal.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_SUB_OVF_EN
    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, ovf
    );
    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, ovf
    );
`else
    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out
    );
    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor: diff = a - b - borrow_in (mod 2^WIDTH), computed
//   LSB first, one bit per clock, with a single full-subtractor cell and a
//   borrow flop. Start/busy/done handshake; operands captured on start.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    serial_subtractor_if.slave (start, a, b, borrow_in in;
//            busy, done, diff, borrow_out [, ovf] out)
//
//   Parameter: WIDTH (2..32), operand/result width.
//   Optional macro: SERIAL_SUB_OVF_EN adds the registered signed-overflow
//   output ovf.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    // Full-subtractor cell on the current LSBs.
    logic             w_d;
    logic             w_br_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_nxt  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    // Result fills from the MSB end, so after WIDTH shifts bit 0 sits at LSB.
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sa         <= '0;
            r_sb         <= '0;
            r_res        <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_ovf        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_br    <= bus.borrow_in;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_br  <= w_br_nxt;
                    r_res <= w_res_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_diff       <= w_res_nxt;
                        r_borrow_out <= w_br_nxt;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_res_nxt[WIDTH-1]);
`endif
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf        = r_ovf;
`endif

endmodule
